// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default coefficient table and width helper for the FIR tap sequencer
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  localparam int FIR_MAX_TAPS = 256;

  // Unity taps: with the write port compiled out the filter is a plain moving sum.
  localparam int FIR_COEF_DEFAULT [FIR_MAX_TAPS] = '{default: 1};

  function automatic int fir_ptr_w(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// rtl/fir_sample_buf.sv - circular sample history, one write port, one asynchronous read port
module fir_sample_buf
  import fir_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int N_TAPS     = 16,
  parameter int PTR_W      = fir_ptr_w(N_TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [PTR_W-1:0]      i_wr_addr,
  input  logic [WIDTH_DATA-1:0] i_wr_data,
  input  logic [PTR_W-1:0]      i_rd_addr,
  output logic [WIDTH_DATA-1:0] o_rd_data
);

  logic [WIDTH_DATA-1:0] r_mem [N_TAPS];

  // Clearing on reset makes samples older than the reset contribute zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - steps (sample, coefficient) pairs into a MAC; FIR_SEQ_COEF_WR_EN adds a coefficient write port
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int WIDTH_COEF = 8,
  parameter int N_TAPS     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH_DATA-1:0]        in_data,
  output logic                         in_ready,
  output logic [WIDTH_DATA-1:0]        mac_a,
  output logic [WIDTH_COEF-1:0]        mac_b,
  output logic                         mac_clear,
  output logic                         out_valid
`ifdef FIR_SEQ_COEF_WR_EN
  ,
  input  logic                         coef_we,
  input  logic [fir_ptr_w(N_TAPS)-1:0] coef_addr,
  input  logic [WIDTH_COEF-1:0]        coef_wdata
`endif
);

  localparam int PTR_W = fir_ptr_w(N_TAPS);
  localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(N_TAPS - 1);

  fir_state_t            r_state;
  fir_state_t            w_state_next;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_newest;
  logic [PTR_W-1:0]      r_tap_cnt;
  logic                  w_accept;
  logic [PTR_W-1:0]      w_rd_addr;
  logic [WIDTH_DATA-1:0] w_rd_data;
  logic [WIDTH_COEF-1:0] w_coef;

  assign w_accept  = in_valid && (r_state != RUN);
  // Power-of-two depth: pointer wrap gives the modulo for free.
  assign w_rd_addr = r_newest - r_tap_cnt;

  fir_sample_buf #(
    .WIDTH_DATA(WIDTH_DATA),
    .N_TAPS    (N_TAPS),
    .PTR_W     (PTR_W)
  ) u_sample_buf (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_accept),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(in_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

`ifdef FIR_SEQ_COEF_WR_EN
  logic [WIDTH_COEF-1:0] r_coef [N_TAPS];

  always_ff @(posedge clk) begin
    if (coef_we) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  assign w_coef = r_coef[r_tap_cnt];
`else
  assign w_coef = WIDTH_COEF'(FIR_COEF_DEFAULT[8'(r_tap_cnt)]);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_newest  <= '0;
      r_tap_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_newest  <= r_wr_ptr;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_tap_cnt <= '0;
      end else if (r_state == RUN) begin
        r_tap_cnt <= r_tap_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    mac_a        = '0;
    mac_b        = '0;
    mac_clear    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        in_ready  = 1'b0;
        mac_a     = w_rd_data;
        mac_b     = w_coef;
        mac_clear = (r_tap_cnt == '0);
        if (r_tap_cnt == LAST_TAP) w_state_next = DONE;
      end
      DONE: begin
        out_valid    = 1'b1;
        w_state_next = w_accept ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
